// File: rtl/serial_bit_counter_if.sv
// rtl/serial_bit_counter_if.sv - control/data bundle between the receive FSM and the bit counter datapath
interface serial_bit_counter_if #(
    parameter int DATA_W = 8
);
    logic              SerI;
    logic              En_reg;
    logic              Init_Reg;
    logic              Init_Cnt;
    logic              Inc_Cnt;
    logic [DATA_W-1:0] Reg_Out;
    logic              CO;

    modport master (
        output SerI,
        output En_reg,
        output Init_Reg,
        output Init_Cnt,
        output Inc_Cnt,
        input  Reg_Out,
        input  CO
    );

    modport slave (
        input  SerI,
        input  En_reg,
        input  Init_Reg,
        input  Init_Cnt,
        input  Inc_Cnt,
        output Reg_Out,
        output CO
    );
endinterface

// File: rtl/serial_bit_counter.sv
// rtl/serial_bit_counter.sv - LSB-first receive shift register with modulo-DATA_W bit counter and frame carry-out
module serial_bit_counter #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 3
) (
    input  logic                 Clk,
    input  logic                 Rst,
    serial_bit_counter_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    if (CNT_W != $clog2(DATA_W)) begin : g_bad_cnt_w
        $error("serial_bit_counter: CNT_W must equal clog2(DATA_W)");
    end

    logic [DATA_W-1:0] shreg_q;
    logic [DATA_W-1:0] shreg_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              cnt_at_last;

    assign cnt_at_last = (cnt_q == CNT_LAST);

    always_comb begin
        shreg_d = shreg_q;
        if (bus.Init_Reg) begin
            shreg_d = '0;
        end else if (bus.En_reg) begin
            shreg_d = {bus.SerI, shreg_q[DATA_W-1:1]};
        end
    end

    // Explicit wrap keeps the counter correct even if DATA_W is not a power of two.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.Init_Cnt) begin
            cnt_d = '0;
        end else if (bus.Inc_Cnt) begin
            cnt_d = cnt_at_last ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.Reg_Out = shreg_q;
    assign bus.CO      = bus.Inc_Cnt & cnt_at_last & ~Rst & ~bus.Init_Cnt;
endmodule

// File: tb/tb_serial_bit_counter.sv
// tb/tb_serial_bit_counter.sv - directed-vector bench for serial_bit_counter
module tb_serial_bit_counter;
    logic Clk = 1'b0;
    logic Rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    serial_bit_counter_if #(.DATA_W(8)) bus ();

    serial_bit_counter #(.DATA_W(8), .CNT_W(3)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic ser, input logic en, input logic ir,
                         input logic ic, input logic inc);
        bus.SerI     = ser;
        bus.En_reg   = en;
        bus.Init_Reg = ir;
        bus.Init_Cnt = ic;
        bus.Inc_Cnt  = inc;
        #1;
    endtask

    logic [7:0] frame1 = 8'b0110_1110;
    logic [3:0] frame2 = 4'b0001;

    initial begin
        // reset with busy inputs
        Rst = 1'b1;
        drive(1, 1, 0, 0, 1);
        tick();
        check("rst_reg", bus.Reg_Out, 8'h00);
        check("rst_cnt", dut.cnt_q, 0);
        check("rst_co", bus.CO, 0);
        Rst = 1'b0;

        // init beats enables
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 1, 1, 1);
            check("init_co", bus.CO, 0);
            tick();
            check("init_reg", bus.Reg_Out, 8'h00);
            check("init_cnt", dut.cnt_q, 0);
        end

        // first frame, LSB first: bits 0,1,1,1,0,1,1,0
        for (int i = 0; i < 8; i++) begin
            drive(frame1[i], 1, 0, 0, 1);
            check($sformatf("f1_co%0d", i), bus.CO, (i == 7) ? 1 : 0);
            tick();
        end
        check("f1_reg", bus.Reg_Out, 8'h6E);
        check("f1_cnt", dut.cnt_q, 0);

        // continue across the wrap: 1,0,0,0
        for (int i = 0; i < 4; i++) begin
            drive(frame2[i], 1, 0, 0, 1);
            check($sformatf("f2_co%0d", i), bus.CO, 0);
            tick();
        end
        check("f2_reg", bus.Reg_Out, 8'h16);
        check("f2_cnt", dut.cnt_q, 4);

        // count without shifting
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 1);
            tick();
        end
        check("cnt_only_reg", bus.Reg_Out, 8'h16);
        check("cnt_only_cnt", dut.cnt_q, 7);
        drive(0, 0, 0, 0, 1);
        check("co_at_7", bus.CO, 1);

        // shift without counting
        drive(1, 1, 0, 0, 0);
        check("co_no_inc", bus.CO, 0);
        tick();
        check("shift_only_reg", bus.Reg_Out, 8'h8B);
        check("shift_only_cnt", dut.cnt_q, 7);

        // Init_Reg alone leaves count
        drive(1, 1, 1, 0, 1);
        check("ireg_co", bus.CO, 1);
        tick();
        check("ireg_reg", bus.Reg_Out, 8'h00);
        check("ireg_cnt", dut.cnt_q, 0);

        // count back up to 7, then Init_Cnt alone
        for (int i = 0; i < 7; i++) begin
            drive(0, 0, 0, 0, 1);
            tick();
        end
        drive(1, 1, 0, 1, 1);
        check("icnt_co_forced", bus.CO, 0);
        tick();
        check("icnt_reg", bus.Reg_Out, 8'h80);
        check("icnt_cnt", dut.cnt_q, 0);

        // five bits of ones, then reset mid-frame
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0, 0, 1);
            tick();
        end
        check("mid_reg", bus.Reg_Out, 8'hFC);
        check("mid_cnt", dut.cnt_q, 5);
        Rst = 1'b1;
        drive(1, 1, 0, 0, 1);
        check("mid_rst_co", bus.CO, 0);
        tick();
        check("mid_rst_reg", bus.Reg_Out, 8'h00);
        check("mid_rst_cnt", dut.cnt_q, 0);
        Rst = 1'b0;

        // Rst must force CO low even at count 7
        for (int i = 0; i < 7; i++) begin
            drive(0, 0, 0, 0, 1);
            tick();
        end
        check("pre_rst7_cnt", dut.cnt_q, 7);
        Rst = 1'b1;
        drive(0, 0, 0, 0, 1);
        check("rst7_co", bus.CO, 0);
        tick();
        check("rst7_cnt", dut.cnt_q, 0);
        Rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
